// File: rtl/robo_pkg.sv
// Shared encodings for the robot map updater: command opcodes, gamepad
// button positions and the command scheduler's FSM states.
package robo_pkg;

   typedef enum logic [1:0] {
      OP_NONE    = 2'b00,
      OP_AVANCAR = 2'b01,
      OP_GIRAR   = 2'b10,
      OP_REMOVER = 2'b11
   } op_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_t;

   localparam int unsigned BTN_UP    = 0;
   localparam int unsigned BTN_RIGHT = 1;
   localparam int unsigned BTN_A     = 4;
   localparam int unsigned BTN_START = 7;

   // Autonomous request priority: remover > girar > avancar.
   function automatic op_t auto_op(input logic rem, input logic gir, input logic ava);
      if (rem) return OP_REMOVER;
      if (gir) return OP_GIRAR;
      if (ava) return OP_AVANCAR;
      return OP_NONE;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO of 2-bit command opcodes. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; flush wins over push.
module cmd_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  logic       flush,
   input  logic [1:0] din,
   output logic [1:0] dout,
   output logic       full,
   output logic       empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [1:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/escalonador_comandos.sv
// Frame-paced command scheduler: merges queued gamepad commands and Robo FSM
// requests into at most one valid/ready transfer per VGA frame.
module escalonador_comandos
   import robo_pkg::*;
#(
   parameter int unsigned FRAMES_PER_STEP = 8,
   parameter int unsigned FIFO_DEPTH      = 4,
   parameter int unsigned BTN_W           = 12
) (
   input  logic             Clock50,
   input  logic             Reset,
   input  logic             v_sync,
   input  logic [BTN_W-1:0] Entradas,
   input  logic             auto_avancar,
   input  logic             auto_girar,
   input  logic             auto_remover,
   output logic             auto_ack,
   output logic             cmd_valid,
   output logic [1:0]       cmd_op,
   input  logic             cmd_ready,
   output logic             modo_auto,
   output logic [7:0]       drop_count
);

   localparam int unsigned CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

   state_t        state, state_next;
   op_t           op_q, op_next;
   logic          vs_meta, vs_sync, vs_prev, frame_tick;
   logic [3:0]    btn_q, btn_prev, btn_edge;
   logic          unused_btns;
   logic          up_e, right_e, a_e, start_e;
   logic          push_req, drop;
   op_t           push_op;
   logic          toggle_pending, apply_toggle, transfer, step_due;
   logic [CW-1:0] frame_cnt;
   logic          fifo_pop, fifo_full, fifo_empty;
   logic [1:0]    fifo_head;

   assign unused_btns = ^Entradas;
   assign frame_tick  = vs_prev & ~vs_sync;
   assign btn_edge    = btn_q & ~btn_prev;
   assign {start_e, a_e, right_e, up_e} = btn_edge;

   assign push_req = a_e | right_e | up_e;
   assign push_op  = a_e ? OP_REMOVER : (right_e ? OP_GIRAR : OP_AVANCAR);

   assign transfer     = (state == ST_ISSUE) & cmd_ready;
   assign apply_toggle = (state == ST_IDLE) & (start_e | toggle_pending);
   assign step_due     = modo_auto & frame_tick & (frame_cnt == CW'(FRAMES_PER_STEP - 1));
   assign fifo_pop     = transfer & ~modo_auto;
   assign drop         = push_req & fifo_full & ~fifo_pop & ~apply_toggle;

   assign cmd_valid = (state == ST_ISSUE);
   assign cmd_op    = op_q;

   cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (Clock50),
      .rst   (Reset),
      .push  (push_req),
      .pop   (fifo_pop),
      .flush (apply_toggle),
      .din   (push_op),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge Clock50 or posedge Reset) begin
      if (Reset) begin
         state <= ST_IDLE;
         op_q  <= OP_NONE;
      end else begin
         state <= state_next;
         op_q  <= op_next;
      end
   end

   // A mode change flushes the FIFO in the same cycle, so it suppresses any issue then.
   always_comb begin
      state_next = state;
      op_next    = op_q;
      case (state)
         ST_IDLE: begin
            if (frame_tick && !apply_toggle) begin
               if (!modo_auto && !fifo_empty) begin
                  op_next    = op_t'(fifo_head);
                  state_next = ST_ISSUE;
               end else if (step_due && (auto_remover || auto_girar || auto_avancar)) begin
                  op_next    = auto_op(auto_remover, auto_girar, auto_avancar);
                  state_next = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            if (cmd_ready) begin
               op_next    = OP_NONE;
               state_next = ST_IDLE;
            end
         end
         default: begin
            op_next    = OP_NONE;
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock50 or posedge Reset) begin
      if (Reset) begin
         vs_meta        <= 1'b0;
         vs_sync        <= 1'b0;
         vs_prev        <= 1'b0;
         btn_q          <= '0;
         btn_prev       <= '0;
         modo_auto      <= 1'b0;
         toggle_pending <= 1'b0;
         frame_cnt      <= '0;
         auto_ack       <= 1'b0;
         drop_count     <= '0;
      end else begin
         vs_meta  <= v_sync;
         vs_sync  <= vs_meta;
         vs_prev  <= vs_sync;
         btn_q    <= {Entradas[BTN_START], Entradas[BTN_A], Entradas[BTN_RIGHT], Entradas[BTN_UP]};
         btn_prev <= btn_q;
         auto_ack <= transfer & modo_auto;

         if (apply_toggle) begin
            modo_auto      <= ~modo_auto;
            toggle_pending <= 1'b0;
         end else if ((state == ST_ISSUE) && start_e) begin
            toggle_pending <= 1'b1;
         end

         if (apply_toggle)
            frame_cnt <= '0;
         else if (modo_auto && frame_tick)
            frame_cnt <= (frame_cnt == CW'(FRAMES_PER_STEP - 1)) ? '0 : frame_cnt + 1'b1;

         if (drop && (drop_count != '1)) drop_count <= drop_count + 1'b1;
      end
   end

endmodule
